eq_gain_mixer: RTL and testbench

- Parametrised successor of the two-channel equalizer gain stage.
- Takes per-band filter outputs for N channels and weights each band by a CPU-programmed signed gain.
- Sums the bands per channel, then rounds and saturates the sum to the output width.
- Adds double-buffered (shadow/active) gains committed on frame boundaries, bypass-to-single-band mode, a ready/valid handshake, and sticky saturation/overrun flags.
- Sits between the filter bank and the output formatter.

---
 rtl/eq_mix_pkg.sv | 40 ++++
 rtl/eq_gain_bank.sv | 60 ++++++
 rtl/eq_gain_mixer.sv | 237 +++++++++++++++++++++++
 tb/tb_eq_gain_mixer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_mix_pkg.sv
// Shared types and helpers for the equalizer gain mixer.
package eq_mix_pkg;

    localparam int unsigned WIDE_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Accumulator width: full product plus growth for summing every band.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned gain_w,
                                              input int unsigned num_bands);
        return data_w + gain_w + $clog2(num_bands);
    endfunction

    // Unity gain in the fixed-point gain format.
    function automatic logic [31:0] unity_gain(input int unsigned frac);
        return 32'(1) << frac;
    endfunction

    // Clamp a wide signed value into a signed range of the given width.
    function automatic logic signed [WIDE_W-1:0] saturate(input logic signed [WIDE_W-1:0] value,
                                                          input int unsigned width);
        logic signed [WIDE_W-1:0] max_v;
        logic signed [WIDE_W-1:0] min_v;
        max_v = (128'sd1 <<< (width - 1)) - 128'sd1;
        min_v = -max_v - 128'sd1;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/eq_gain_bank.sv
// Shadow/active gain register files with auto-increment write port and frame-boundary commit.
module eq_gain_bank import eq_mix_pkg::*; #(
    parameter int unsigned NUM_BANDS = 4,
    parameter int unsigned GAIN_W    = 16,
    parameter int unsigned GAIN_FRAC = 14
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         gain_wr,
    input  logic                         gain_wr_rst,
    input  logic [GAIN_W-1:0]            gain_wr_data,
    input  logic                         gain_commit,
    input  logic                         copy_en,
    input  logic [$clog2(NUM_BANDS)-1:0] rd_band,
    output logic [GAIN_W-1:0]            rd_gain_c,
    output logic [$clog2(NUM_BANDS)-1:0] gain_wr_addr,
    output logic                         commit_pending
);

    localparam int unsigned       BAND_W = $clog2(NUM_BANDS);
    localparam logic [GAIN_W-1:0] UNITY  = GAIN_W'(unity_gain(GAIN_FRAC));

    logic [GAIN_W-1:0] shadow_q [NUM_BANDS];
    logic [GAIN_W-1:0] active_q [NUM_BANDS];

    // Gain storage, write address and pending-commit tracking.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_BANDS); i++) begin
                shadow_q[i] <= UNITY;
                active_q[i] <= UNITY;
            end
            gain_wr_addr   <= '0;
            commit_pending <= 1'b0;
        end else begin
            if (gain_wr) begin
                shadow_q[gain_wr_addr] <= gain_wr_data;
            end
            if (gain_wr_rst) begin
                gain_wr_addr <= '0;
            end else if (gain_wr) begin
                gain_wr_addr <= (gain_wr_addr == BAND_W'(NUM_BANDS - 1)) ? '0
                                                                         : gain_wr_addr + BAND_W'(1);
            end
            // Copy uses the pre-write shadow; a commit on the copy edge arms the next frame.
            if (copy_en && commit_pending) begin
                for (int i = 0; i < int'(NUM_BANDS); i++) begin
                    active_q[i] <= shadow_q[i];
                end
                commit_pending <= gain_commit;
            end else if (gain_commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // Read port driven by the band counter.
    assign rd_gain_c = active_q[rd_band];

endmodule

// File: rtl/eq_gain_mixer.sv
// Per-channel weighted band sum with rounding-by-truncation and saturation.
module eq_gain_mixer import eq_mix_pkg::*; #(
    parameter int unsigned NUM_BANDS    = 4,
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned DATA_W       = 48,
    parameter int unsigned GAIN_W       = 16,
    parameter int unsigned GAIN_FRAC    = 14,
    parameter int unsigned OUT_W        = 24,
    parameter int unsigned OUT_SHIFT    = 38
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       run,
    input  logic                                       bypass,
    input  logic [$clog2(NUM_BANDS)-1:0]               bypass_sel,
    input  logic                                       gain_wr,
    input  logic                                       gain_wr_rst,
    input  logic [GAIN_W-1:0]                          gain_wr_data,
    input  logic                                       gain_commit,
    output logic [$clog2(NUM_BANDS)-1:0]               gain_wr_addr,
    output logic                                       commit_pending,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [NUM_CHANNELS*NUM_BANDS*DATA_W-1:0]   in_data,
    output logic                                       out_valid,
    output logic [NUM_CHANNELS*OUT_W-1:0]              out_data,
    output logic                                       sat_flag,
    output logic                                       overrun_flag,
    input  logic                                       flag_clr
);

    localparam int unsigned       BAND_W = $clog2(NUM_BANDS);
    localparam int unsigned       CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned       PROD_W = DATA_W + GAIN_W;
    localparam int unsigned       ACC_W  = acc_width(DATA_W, GAIN_W, NUM_BANDS);
    localparam logic [GAIN_W-1:0] UNITY  = GAIN_W'(unity_gain(GAIN_FRAC));

    state_t state_q, state_d;
    logic   accept_c, last_mul_c;

    logic [BAND_W-1:0]        band_q;
    logic [CH_W-1:0]          ch_q;
    logic                     drain_q;
    logic signed [DATA_W-1:0] hold_q [NUM_CHANNELS][NUM_BANDS];
    logic                     byp_q;
    logic [BAND_W-1:0]        byp_sel_q;

    logic [GAIN_W-1:0]        bank_gain_c;
    logic signed [GAIN_W-1:0] gain_c;
    logic signed [DATA_W-1:0] sample_c;
    logic signed [PROD_W-1:0] prod_c;

    logic signed [PROD_W-1:0] prod_q;
    logic                     prod_vld_q, prod_first_q, prod_last_q;
    logic [CH_W-1:0]          prod_ch_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     acc_last_q;
    logic [CH_W-1:0]          acc_ch_q;

    logic signed [ACC_W-1:0]  shifted_c;
    logic signed [WIDE_W-1:0] wide_c, sat_c;
    logic                     clamp_c;
    logic [OUT_W-1:0]         res_q [NUM_CHANNELS];
    logic                     frame_sat_q;

    eq_gain_bank #(
        .NUM_BANDS (NUM_BANDS),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_bank (
        .clk            (clk),
        .reset_n        (reset_n),
        .gain_wr        (gain_wr),
        .gain_wr_rst    (gain_wr_rst),
        .gain_wr_data   (gain_wr_data),
        .gain_commit    (gain_commit),
        .copy_en        (accept_c),
        .rd_band        (band_q),
        .rd_gain_c      (bank_gain_c),
        .gain_wr_addr   (gain_wr_addr),
        .commit_pending (commit_pending)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping run aborts any in-flight frame.
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        last_mul_c = (band_q == BAND_W'(NUM_BANDS - 1)) && (ch_q == CH_W'(NUM_CHANNELS - 1));
        case (state_q)
            IDLE: begin
                if (in_valid && run) begin
                    accept_c = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (last_mul_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (drain_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiplier operand selection and result shift/saturate.
    always_comb begin
        sample_c  = hold_q[ch_q][band_q];
        gain_c    = byp_q ? ((band_q == byp_sel_q) ? UNITY : '0) : bank_gain_c;
        prod_c    = PROD_W'(sample_c) * PROD_W'(gain_c);
        shifted_c = acc_q >>> OUT_SHIFT;
        wide_c    = {{(WIDE_W - ACC_W){shifted_c[ACC_W-1]}}, shifted_c};
        sat_c     = saturate(wide_c, OUT_W);
        clamp_c   = (sat_c != wide_c);
    end

    // Frame capture and channel/band sequencing.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                for (int b = 0; b < int'(NUM_BANDS); b++) begin
                    hold_q[c][b] <= '0;
                end
            end
            byp_q     <= 1'b0;
            byp_sel_q <= '0;
            band_q    <= '0;
            ch_q      <= '0;
            drain_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                    for (int b = 0; b < int'(NUM_BANDS); b++) begin
                        hold_q[c][b] <= in_data[(c*int'(NUM_BANDS)+b)*int'(DATA_W) +: DATA_W];
                    end
                end
                byp_q     <= bypass;
                byp_sel_q <= bypass_sel;
                band_q    <= '0;
                ch_q      <= '0;
            end else if (state_q == RUN) begin
                if (band_q == BAND_W'(NUM_BANDS - 1)) begin
                    band_q <= '0;
                    ch_q   <= ch_q + CH_W'(1);
                end else begin
                    band_q <= band_q + BAND_W'(1);
                end
            end
            drain_q <= (state_q == DRAIN) && !drain_q;
        end
    end

    // Product register, per-channel accumulator and saturated result staging.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prod_q       <= '0;
            prod_vld_q   <= 1'b0;
            prod_first_q <= 1'b0;
            prod_last_q  <= 1'b0;
            prod_ch_q    <= '0;
            acc_q        <= '0;
            acc_last_q   <= 1'b0;
            acc_ch_q     <= '0;
            frame_sat_q  <= 1'b0;
            for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                res_q[c] <= '0;
            end
        end else begin
            prod_vld_q   <= (state_q == RUN) && run;
            prod_q       <= prod_c;
            prod_first_q <= (band_q == '0);
            prod_last_q  <= (band_q == BAND_W'(NUM_BANDS - 1));
            prod_ch_q    <= ch_q;
            if (prod_vld_q && run) begin
                acc_q <= prod_first_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
            end
            acc_last_q <= prod_vld_q && prod_last_q && run;
            acc_ch_q   <= prod_ch_q;
            if (accept_c) begin
                frame_sat_q <= 1'b0;
            end else if (acc_last_q && run) begin
                res_q[acc_ch_q] <= OUT_W'(sat_c);
                if (clamp_c) begin
                    frame_sat_q <= 1'b1;
                end
            end
        end
    end

    // Handshake, result publication and sticky flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_data     <= '0;
            sat_flag     <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_q == DONE) && run;
            if ((state_q == DONE) && run) begin
                for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                    out_data[c*int'(OUT_W) +: OUT_W] <= res_q[c];
                end
            end
            if ((state_q == DONE) && run && frame_sat_q) begin
                sat_flag <= 1'b1;
            end else if (flag_clr) begin
                sat_flag <= 1'b0;
            end
            if (in_valid && !in_ready) begin
                overrun_flag <= 1'b1;
            end else if (flag_clr) begin
                overrun_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eq_gain_mixer.sv
// Scoreboard bench for eq_gain_mixer at default parameters.
module tb_eq_gain_mixer;

    localparam int NB = 4;
    localparam int NC = 2;
    localparam int DW = 48;
    localparam int GW = 16;
    localparam int OW = 24;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              run;
    logic              bypass;
    logic [1:0]        bypass_sel;
    logic              gain_wr;
    logic              gain_wr_rst;
    logic [GW-1:0]     gain_wr_data;
    logic              gain_commit;
    logic [1:0]        gain_wr_addr;
    logic              commit_pending;
    logic              in_valid;
    logic              in_ready;
    logic [NC*NB*DW-1:0] in_data;
    logic              out_valid;
    logic [NC*OW-1:0]  out_data;
    logic              sat_flag;
    logic              overrun_flag;
    logic              flag_clr;

    eq_gain_mixer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .run            (run),
        .bypass         (bypass),
        .bypass_sel     (bypass_sel),
        .gain_wr        (gain_wr),
        .gain_wr_rst    (gain_wr_rst),
        .gain_wr_data   (gain_wr_data),
        .gain_commit    (gain_commit),
        .gain_wr_addr   (gain_wr_addr),
        .commit_pending (commit_pending),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .sat_flag       (sat_flag),
        .overrun_flag   (overrun_flag),
        .flag_clr       (flag_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC*OW-1:0] data;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               total = 0;
    int               bad   = 0;
    int               cyc   = 0;
    int               n_out = 0;
    logic [NC*OW-1:0] last_out = '0;
    logic [GW-1:0]    tb_shadow [NB];
    logic [GW-1:0]    tb_active [NB];
    logic             tb_pending;
    int               tb_addr;
    int               n0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pop the scoreboard on each result strobe and check data and latency.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid) begin
            n_out++;
            last_out = out_data;
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'h1, 64'h0);
            end else begin
                e = sb.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("latency", 64'(cyc - e.cyc), 64'd11);
            end
        end
    end

    function automatic logic [NC*NB*DW-1:0] frame_all(input logic [DW-1:0] v);
        logic [NC*NB*DW-1:0] f;
        for (int i = 0; i < NC*NB; i++) f[i*DW +: DW] = v;
        return f;
    endfunction

    function automatic logic [NC*OW-1:0] model(input logic [NC*NB*DW-1:0] d,
                                               input logic byp, input logic [1:0] sel);
        logic [NC*OW-1:0]  r;
        logic signed [127:0] acc, s, g, sh;
        logic [DW-1:0]     sv;
        logic [GW-1:0]     gv;
        r = '0;
        for (int ch = 0; ch < NC; ch++) begin
            acc = '0;
            for (int b = 0; b < NB; b++) begin
                sv  = d[(ch*NB+b)*DW +: DW];
                gv  = byp ? ((2'(b) == sel) ? 16'h4000 : 16'h0000) : tb_active[b];
                s   = {{(128-DW){sv[DW-1]}}, sv};
                g   = {{(128-GW){gv[GW-1]}}, gv};
                acc = acc + s * g;
            end
            sh = acc >>> 38;
            if (sh > 128'sd8388607) sh = 128'sd8388607;
            else if (sh < -128'sd8388608) sh = -128'sd8388608;
            r[ch*OW +: OW] = sh[OW-1:0];
        end
        return r;
    endfunction

    task automatic send_frame(input logic [NC*NB*DW-1:0] d, input logic byp,
                              input logic [1:0] sel, input bit expect_out);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 64'h0, 64'h1);
        in_data    = d;
        bypass     = byp;
        bypass_sel = sel;
        in_valid   = 1'b1;
        if (tb_pending) begin
            tb_active  = tb_shadow;
            tb_pending = 1'b0;
        end
        e.data = model(d, byp, sel);
        @(negedge clk);
        e.cyc    = cyc;
        in_valid = 1'b0;
        bypass   = 1'b0;
        if (expect_out) sb.push_back(e);
    endtask

    task automatic wait_out();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("out_timeout", 64'h0, 64'h1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wr_gain(input logic [GW-1:0] v);
        gain_wr      = 1'b1;
        gain_wr_data = v;
        @(negedge clk);
        gain_wr = 1'b0;
        tb_shadow[tb_addr] = v;
        tb_addr = (tb_addr + 1) % NB;
    endtask

    task automatic wr_rst();
        gain_wr_rst = 1'b1;
        @(negedge clk);
        gain_wr_rst = 1'b0;
        tb_addr = 0;
    endtask

    task automatic commit();
        gain_commit = 1'b1;
        @(negedge clk);
        gain_commit = 1'b0;
        tb_pending = 1'b1;
    endtask

    task automatic clr_flags();
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; bypass = 1'b0; bypass_sel = '0;
        gain_wr = 1'b0; gain_wr_rst = 1'b0; gain_wr_data = '0; gain_commit = 1'b0;
        in_valid = 1'b0; in_data = '0; flag_clr = 1'b0;
        for (int i = 0; i < NB; i++) begin
            tb_shadow[i] = 16'h4000;
            tb_active[i] = 16'h4000;
        end
        tb_pending = 1'b0;
        tb_addr    = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_sat", 64'(sat_flag), 64'h0);
        chk("rst_ovr", 64'(overrun_flag), 64'h0);
        chk("rst_wr_addr", 64'(gain_wr_addr), 64'h0);
        chk("rst_pending", 64'(commit_pending), 64'h0);
        run = 1'b1;
        @(negedge clk);

        // Unity gains, every band 1<<24
        send_frame(frame_all(48'h000001_000000), 1'b0, 2'd0, 1'b1);
        wait_out();
        chk("unity_out", 64'(last_out), 64'h000004_000004);

        // Mixed gains {1, 0, 0, -0.5}
        wr_rst();
        wr_gain(16'h4000); wr_gain(16'h0000); wr_gain(16'h0000); wr_gain(16'hE000);
        chk("wr_addr_wrap4", 64'(gain_wr_addr), 64'h0);
        commit();
        chk("pending_set", 64'(commit_pending), 64'h1);
        in_data = frame_all(48'h000002_000000);
        in_data[0*DW +: DW] = 48'h000001_000000;
        in_data[1*DW +: DW] = 48'h000005_000000;
        in_data[2*DW +: DW] = 48'h000005_000000;
        in_data[3*DW +: DW] = 48'h000004_000000;
        send_frame(in_data, 1'b0, 2'd0, 1'b1);
        wait_out();
        chk("mixed_l", 64'(last_out[OW-1:0]), 64'hFFFFFF);
        chk("mixed_r", 64'(last_out[2*OW-1:OW]), 64'h000001);
        chk("pending_clr", 64'(commit_pending), 64'h0);

        // Saturation both directions, then clear
        wr_gain(16'h4000); wr_gain(16'h4000); wr_gain(16'h4000); wr_gain(16'h4000);
        commit();
        send_frame(frame_all(48'h7FFFFF_000000), 1'b0, 2'd0, 1'b1);
        wait_out();
        chk("sat_pos", 64'(last_out), 64'h7FFFFF_7FFFFF);
        chk("sat_flag", 64'(sat_flag), 64'h1);
        send_frame(frame_all(48'h800000_000000), 1'b0, 2'd0, 1'b1);
        wait_out();
        chk("sat_neg", 64'(last_out), 64'h800000_800000);
        clr_flags();
        chk("sat_clr", 64'(sat_flag), 64'h0);

        // Bypass band 2
        in_data = frame_all(48'h7FFFFF_000000);
        in_data[2*DW +: DW]      = 48'h000123_000000;
        in_data[(NB+2)*DW +: DW] = 48'h000123_000000;
        send_frame(in_data, 1'b1, 2'd2, 1'b1);
        wait_out();
        chk("bypass_out", 64'(last_out), 64'h000123_000123);
        chk("bypass_nosat", 64'(sat_flag), 64'h0);
        send_frame(frame_all(48'h000001_000000), 1'b0, 2'd0, 1'b1);
        wait_out();
        chk("post_bypass", 64'(last_out), 64'h000004_000004);

        // Commit mid-frame only affects the next frame
        send_frame(frame_all(48'h000001_000000), 1'b0, 2'd0, 1'b1);
        repeat (2) @(negedge clk);
        wr_gain(16'h0000); wr_gain(16'h0000); wr_gain(16'h0000); wr_gain(16'h0000);
        commit();
        wait_out();
        chk("midcommit_cur", 64'(last_out), 64'h000004_000004);
        chk("midcommit_pend", 64'(commit_pending), 64'h1);
        send_frame(frame_all(48'h000001_000000), 1'b0, 2'd0, 1'b1);
        wait_out();
        chk("midcommit_next", 64'(last_out), 64'h0);
        chk("midcommit_pclr", 64'(commit_pending), 64'h0);

        // Overrun while busy
        n0 = n_out;
        send_frame(frame_all(48'h000003_000000), 1'b0, 2'd0, 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out();
        repeat (15) @(negedge clk);
        chk("overrun_count", 64'(n_out - n0), 64'h1);
        chk("overrun_flag", 64'(overrun_flag), 64'h1);
        clr_flags();
        chk("overrun_clr", 64'(overrun_flag), 64'h0);

        // Abort mid-RUN keeps out_data and the pending commit
        send_frame(frame_all(48'h000002_000000), 1'b0, 2'd0, 1'b0);
        wr_gain(16'h4000); wr_gain(16'h4000); wr_gain(16'h4000); wr_gain(16'h4000);
        commit();
        run = 1'b0;
        @(negedge clk);
        chk("abort_ready", 64'(in_ready), 64'h1);
        run = 1'b1;
        n0 = n_out;
        repeat (15) @(negedge clk);
        chk("abort_no_out", 64'(n_out - n0), 64'h0);
        chk("abort_data", 64'(out_data), 64'h0);
        chk("abort_pending", 64'(commit_pending), 64'h1);
        send_frame(frame_all(48'h000001_000000), 1'b0, 2'd0, 1'b1);
        wait_out();
        chk("after_abort", 64'(last_out), 64'h000004_000004);
        chk("after_abort_pclr", 64'(commit_pending), 64'h0);

        // Five writes wrap the address to 1
        wr_rst();
        for (int i = 0; i < 5; i++) wr_gain(16'h4000);
        chk("wr_addr_wrap5", 64'(gain_wr_addr), 64'h1);
        chk("wr_addr_model", 64'(gain_wr_addr), 64'(tb_addr));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
